// File: rtl/irq_priority_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the 8-source interrupt controller.
package irq_priority_ctrl_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } irq_state_e;

  function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    return {{(N_SRC-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/irq_priority_ctrl_if.sv
// Issue/acknowledge channel between the interrupt controller and its servicer.
// irq_out acts as valid and irq_ack as ready: an issue is consumed on the edge where
// both are high, and irq_id stays stable from the first valid cycle until that edge.
interface irq_priority_ctrl_if
  import irq_priority_ctrl_pkg::*;
();
  logic            irq_out;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;

  modport master (output irq_out, output irq_id, input irq_ack);
  modport slave  (input irq_out, input irq_id, output irq_ack);
endinterface

// File: rtl/irq_priority_ctrl_prio_enc.sv
// 8-to-3 priority encoder: reports the highest set request index (bit 7 highest).
module priority_encoder (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  always_comb begin
    idx_o   = 3'd0;
    valid_o = |req_i;
    // Ascending scan so the last (highest) set bit overwrites earlier ones.
    for (int i = 0; i < 8; i++) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Edge-captured, maskable interrupt controller that issues one source at a time
// and inserts a deasserted cycle between consecutive issues.
module irq_priority_ctrl
  import irq_priority_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     irq_in,
  input  logic                 mask_wr,
  input  logic [N_SRC-1:0]     mask_din,
  irq_priority_ctrl_if.master  irq_bus,
  output logic [N_SRC-1:0]     pending,
  output logic [N_SRC-1:0]     mask,
  output irq_state_e           dbg_state_o
);

  logic [N_SRC-1:0] irq_in_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] sel;
  logic [ID_W-1:0]  enc_idx;
  logic             enc_valid;
  irq_state_e       state_q;
  logic             irq_out_q;
  logic [ID_W-1:0]  irq_id_q;
  logic             ack_taken;

  assign rise      = irq_in & ~irq_in_q;
  assign ack_taken = (state_q == ISSUE) && irq_bus.irq_ack;
  assign clr       = ack_taken ? id_onehot(irq_id_q) : '0;
  assign sel       = pending_q & ~mask_q;

  // Set is OR'd in after the clear so a same-edge re-request is never lost.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_wr ? mask_din : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_in_q  <= '0;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      irq_in_q  <= irq_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  priority_encoder u_prio_enc (
    .req_i   (sel),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_out_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_valid) begin
            irq_id_q  <= enc_idx;
            irq_out_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          // No preemption and no withdrawal: only an acknowledge ends the issue.
          if (irq_bus.irq_ack) begin
            irq_out_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          irq_out_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          irq_out_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign irq_bus.irq_out = irq_out_q;
  assign irq_bus.irq_id  = irq_id_q;
  assign pending         = pending_q;
  assign mask            = mask_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed vector table, hand sequences, then random traffic
// against a behavioural model of the issue/ack rules.
module tb_irq_priority_ctrl;
  import irq_priority_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic [7:0] pending;
  logic [7:0] mask;
  irq_state_e dbg_state;

  irq_priority_ctrl_if bus ();

  irq_priority_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .mask_wr     (mask_wr),
    .mask_din    (mask_din),
    .irq_bus     (bus),
    .pending     (pending),
    .mask        (mask),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending kept as a per-source bit array; the servicer-facing side as "busy" and "gap" flags.
  bit m_pend [8];
  bit m_mask [8];
  bit m_prev [8];
  bit m_busy;
  bit m_gap;
  int m_id;

  task automatic model_edge(input logic r, input logic [7:0] in_v, input logic mw,
                            input logic [7:0] md, input logic ack);
    int  best;
    int  cleared;
    bit  new_pend [8];
    if (r) begin
      foreach (m_pend[i]) begin
        m_pend[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
      end
      m_busy = 0; m_gap = 0; m_id = 0;
      return;
    end
    cleared = (m_busy && ack) ? m_id : -1;
    foreach (m_pend[i])
      new_pend[i] = (m_pend[i] && (i != cleared)) || (in_v[i] && !m_prev[i]);
    best = -1;
    foreach (m_pend[i])
      if (m_pend[i] && !m_mask[i]) best = i;
    if (m_busy) begin
      if (ack) begin m_busy = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (best >= 0) begin
      m_busy = 1; m_id = best;
    end
    foreach (m_pend[i]) begin
      m_pend[i] = new_pend[i];
      m_prev[i] = in_v[i];
      if (mw) m_mask[i] = md[i];
    end
  endtask

  function automatic logic [7:0] pack8(input bit a [8]);
    logic [7:0] v;
    foreach (a[i]) v[i] = a[i];
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [7:0] in_v, input logic mw,
                      input logic [7:0] md, input logic ack);
    @(negedge clk);
    rst         = r;
    irq_in      = in_v;
    mask_wr     = mw;
    mask_din    = md;
    bus.irq_ack = ack;
    @(posedge clk);
    model_edge(r, in_v, mw, md, ack);
    #1;
  endtask

  task automatic expect_out(input string name, input logic out, input logic [2:0] id,
                            input logic [7:0] pend, input logic [7:0] msk);
    check({name, ".irq_out"}, 32'(bus.irq_out), 32'(out));
    if (out) check({name, ".irq_id"}, 32'(bus.irq_id), 32'(id));
    check({name, ".pending"}, 32'(pending), 32'(pend));
    check({name, ".mask"}, 32'(mask), 32'(msk));
  endtask

  task automatic check_model(input string name);
    logic [1:0] exp_state;
    exp_state = m_busy ? 2'd1 : (m_gap ? 2'd2 : 2'd0);
    check({name, ".irq_out"}, 32'(bus.irq_out), 32'(m_busy));
    if (m_busy) check({name, ".irq_id"}, 32'(bus.irq_id), 32'(m_id));
    check({name, ".pending"}, 32'(pending), 32'(pack8(m_pend)));
    check({name, ".mask"}, 32'(mask), 32'(pack8(m_mask)));
    check({name, ".state"}, 32'(dbg_state), 32'(exp_state));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       r;
    logic [7:0] in_v;
    logic       mw;
    logic [7:0] md;
    logic       ack;
    logic       exp_out;
    logic [2:0] exp_id;
    logic [7:0] exp_pend;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vq[$];

  initial begin
    rst = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_din = '0; bus.irq_ack = 1'b0;

    // rst in  mw md   ack out id pend   mask
    vq.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF}); // reset
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00}); // unmask all
    vq.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h08, 8'h00}); // rise 3
    vq.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00}); // issue 3
    vq.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00}); // hold
    vq.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00}); // ack
    vq.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00}); // gap
    vq.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00}); // level: no reissue
    vq.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00});
    vq.push_back('{1'b0, 8'h24, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24, 8'h00}); // 5 and 2
    vq.push_back('{1'b0, 8'h24, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 8'h24, 8'h00});
    vq.push_back('{1'b0, 8'h24, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h04, 8'h00});
    vq.push_back('{1'b0, 8'h24, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00}); // gap
    vq.push_back('{1'b0, 8'h24, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04, 8'h00});
    vq.push_back('{1'b0, 8'hA4, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84, 8'h00}); // no preempt
    vq.push_back('{1'b0, 8'hA4, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84, 8'h00});
    vq.push_back('{1'b0, 8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h80, 8'h00});
    vq.push_back('{1'b0, 8'hA4, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 8'h00});
    vq.push_back('{1'b0, 8'hA4, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80, 8'h00});
    vq.push_back('{1'b0, 8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 3'd0, 8'h00, 8'h80}); // mask 7
    vq.push_back('{1'b0, 8'h82, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h82, 8'h80});
    vq.push_back('{1'b0, 8'h82, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 8'h82, 8'h80}); // masked 7 skipped
    vq.push_back('{1'b0, 8'h82, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 8'h82, 8'h00});
    vq.push_back('{1'b0, 8'h82, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h80, 8'h00});
    vq.push_back('{1'b0, 8'h82, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 8'h00});
    vq.push_back('{1'b0, 8'h82, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80, 8'h00}); // retained 7
    vq.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00});
    vq.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00}); // ack in gap ignored

    for (int v = 0; v < vq.size(); v++) begin
      step(vq[v].r, vq[v].in_v, vq[v].mw, vq[v].md, vq[v].ack);
      expect_out($sformatf("vec%0d", v), vq[v].exp_out, vq[v].exp_id, vq[v].exp_pend, vq[v].exp_mask);
    end

    // Same-edge ack of id 4 and new rise on line 4: pending survives, id 4 re-issues after GAP.
    step(0, 8'h10, 0, 8'h00, 0); expect_out("conf_rise",  0, 3'd0, 8'h10, 8'h00);
    step(0, 8'h10, 0, 8'h00, 0); expect_out("conf_issue", 1, 3'd4, 8'h10, 8'h00);
    step(0, 8'h00, 0, 8'h00, 0); expect_out("conf_fall",  1, 3'd4, 8'h10, 8'h00);
    step(0, 8'h10, 0, 8'h00, 1); expect_out("conf_ack",   0, 3'd0, 8'h10, 8'h00);
    step(0, 8'h10, 0, 8'h00, 0); expect_out("conf_gap",   0, 3'd0, 8'h10, 8'h00);
    step(0, 8'h10, 0, 8'h00, 0); expect_out("conf_reiss", 1, 3'd4, 8'h10, 8'h00);
    step(0, 8'h10, 1, 8'h10, 0); expect_out("mask_issued",1, 3'd4, 8'h10, 8'h10);
    step(0, 8'h10, 1, 8'h00, 1); expect_out("conf_ack2",  0, 3'd0, 8'h00, 8'h00);
    step(0, 8'h00, 0, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);

    // Reset while issuing, then a line still high when reset drops counts as a rise.
    step(0, 8'h10, 0, 8'h00, 0); expect_out("rst_rise",   0, 3'd0, 8'h10, 8'h00);
    step(0, 8'h10, 0, 8'h00, 0); expect_out("rst_issue",  1, 3'd4, 8'h10, 8'h00);
    step(1, 8'h10, 0, 8'h00, 0); expect_out("rst_mid",    0, 3'd0, 8'h00, 8'hFF);
    check("rst_mid.state", 32'(dbg_state), 32'd0);
    step(0, 8'h10, 0, 8'h00, 0); expect_out("rst_release",0, 3'd0, 8'h10, 8'hFF);
    step(0, 8'h10, 0, 8'h00, 0); expect_out("rst_masked", 0, 3'd0, 8'h10, 8'hFF);

    // Random traffic against the model.
    step(1, 8'h00, 0, 8'h00, 0);
    check_model("rnd_reset");
    begin
      logic [7:0] cur_in;
      cur_in = 8'h00;
      for (int c = 0; c < 800; c++) begin
        logic       r, mw, ack;
        logic [7:0] md;
        r      = ($urandom_range(0, 149) == 0);
        cur_in = cur_in ^ 8'($urandom() & $urandom());
        mw     = ($urandom_range(0, 9) == 0);
        md     = 8'($urandom() & $urandom());
        ack    = ($urandom_range(0, 2) == 0);
        step(r, cur_in, mw, md, ack);
        check_model($sformatf("rnd%0d", c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
